serial_7seg_scan_ctrl: RTL

//  Scan controller for the Serial_7seg AXI4-Lite IP. Takes per-digit bytes from the slave register

---
 rtl/serial_7seg_scan_ctrl_if.sv | 48 ++++
 rtl/serial_7seg_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_7seg_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_7seg_scan_ctrl_if
// Bundle between the Serial_7seg register file and the scan controller.
//
// Signals
//   en          register file -> ctrl   run continuous refresh while high
//   digit_data  register file -> ctrl   byte k = digit k, bit7 = decimal point
//   busy        ctrl -> observer        high from LOAD through final LATCH cycle
//   frame_done  ctrl -> observer        one-cycle pulse when a frame completes
//   sclk        ctrl -> display driver  serial clock
//   sdo         ctrl -> display driver  serial data, MSB first
//   latch       ctrl -> display driver  latch strobe after each 16-bit word
//
// Modports
//   master : drives en/digit_data, observes the controller outputs
//   slave  : the scan controller itself
// ---------------------------------------------------------------------------
interface serial_7seg_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    en;
  logic [NUM_DIGITS*8-1:0] digit_data;
  logic                    busy;
  logic                    frame_done;
  logic                    sclk;
  logic                    sdo;
  logic                    latch;

  modport master (
    output en,
    output digit_data,
    input  busy,
    input  frame_done,
    input  sclk,
    input  sdo,
    input  latch
  );

  modport slave (
    input  en,
    input  digit_data,
    output busy,
    output frame_done,
    output sclk,
    output sdo,
    output latch
  );
endinterface

// File: rtl/serial_7seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// serial_7seg_scan_ctrl
// Scan controller for the Serial_7seg AXI4-Lite IP. Snapshots the per-digit
// bytes at the start of each frame, then for every digit shifts the 16-bit
// word {select, segments} MSB first on sclk/sdo and strobes latch.
//
// Parameters
//   NUM_DIGITS  digits per frame, 1..8
//   CLK_DIV     ACLK cycles per sclk half-period, >= 1
//
// Ports
//   ACLK        system clock, rising edge
//   ARESET      asynchronous, active-high reset
//   bus         serial_7seg_scan_ctrl_if.slave
//                 en, digit_data in; busy, frame_done, sclk, sdo, latch out
//
// Configuration
//   SERIAL_7SEG_HEX_DECODE_EN  defined   : segment byte = {dp, hex decode of
//                                           low nibble}, gfedcba active-high
//                              undefined : segment byte = raw digit byte
// ---------------------------------------------------------------------------
module serial_7seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_DIV    = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  serial_7seg_scan_ctrl_if.slave  bus
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [NUM_DIGITS*8-1:0] r_snap;    // frame snapshot of digit_data
  logic [IDX_W-1:0]        r_idx;     // digit being sent
  logic [DIV_W-1:0]        r_div;     // half-period / latch-width divider
  logic                    r_phase;   // 0 = sclk low half, 1 = sclk high half
  logic [3:0]              r_bit;     // bit number within the 16-bit word
  logic [15:0]             r_shreg;   // outgoing word, MSB on sdo

  logic                    w_div_last;
  logic                    w_last_bit;
  logic                    w_last_digit;
  logic [7:0]              w_byte;
  logic [7:0]              w_seg;
  logic [7:0]              w_sel;

  logic                    w_busy;
  logic                    w_frame_done;
  logic                    w_sclk;
  logic                    w_sdo;
  logic                    w_latch;

  assign w_div_last   = (r_div == DIV_LAST);
  assign w_last_bit   = (r_bit == 4'd15);
  assign w_last_digit = (r_idx == IDX_LAST);

  // Byte of the current digit from the snapshot.
  always_comb begin
    w_byte = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_byte = r_snap[8*i +: 8];
      end
    end
  end

  assign w_sel = 8'd1 << r_idx;

`ifdef SERIAL_7SEG_HEX_DECODE_EN
  function automatic logic [6:0] hexdec(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Bits [6:4] of the digit byte carry no meaning in decode mode.
  logic w_unused_hi;
  assign w_unused_hi = ^w_byte[6:4];

  assign w_seg = {w_byte[7], hexdec(w_byte[3:0])};
`else
  assign w_seg = w_byte;
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and outputs. Outputs decode registered state only, so a reset
  // forces every output low in the same cycle it is asserted.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_busy       = 1'b0;
    w_frame_done = 1'b0;
    w_sclk       = 1'b0;
    w_sdo        = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.en) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_busy      = 1'b1;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        w_busy = 1'b1;
        w_sclk = r_phase;
        w_sdo  = r_shreg[15];
        if (w_div_last && r_phase && w_last_bit) begin
          w_state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        w_busy  = 1'b1;
        w_latch = 1'b1;
        if (w_div_last) begin
          w_state_nxt = w_last_digit ? S_DONE : S_LOAD;
        end
      end
      S_DONE: begin
        w_frame_done = 1'b1;
        w_state_nxt  = bus.en ? S_LOAD : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: snapshot, digit index, divider, bit counter, shift register.
  // The shift happens at the end of the sclk-high half, so the next bit
  // appears on sdo exactly when the low half begins and is held through
  // the following high half.
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_snap  <= '0;
      r_idx   <= '0;
      r_div   <= '0;
      r_phase <= 1'b0;
      r_bit   <= '0;
      r_shreg <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_div <= '0;
          if (bus.en) begin
            r_snap <= bus.digit_data;
            r_idx  <= '0;
          end
        end
        S_LOAD: begin
          r_shreg <= {w_sel, w_seg};
          r_div   <= '0;
          r_phase <= 1'b0;
          r_bit   <= '0;
        end
        S_SHIFT: begin
          if (w_div_last) begin
            r_div <= '0;
            if (r_phase) begin
              r_phase <= 1'b0;
              r_shreg <= {r_shreg[14:0], 1'b0};
              r_bit   <= r_bit + 4'd1;
            end else begin
              r_phase <= 1'b1;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_LATCH: begin
          if (w_div_last) begin
            r_div <= '0;
            // The index only wraps back to 0 through a new snapshot.
            if (!w_last_digit) begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        default: begin
          r_div <= '0;
        end
      endcase
    end
  end

  assign bus.busy       = w_busy;
  assign bus.frame_done = w_frame_done;
  assign bus.sclk       = w_sclk;
  assign bus.sdo        = w_sdo;
  assign bus.latch      = w_latch;

endmodule
